// File: rtl/qea_host_seq.sv
// qea_host_seq: host-side job sequencer for the QEA core.
//
// One job: accept i_go, stream the gate context into the QEA context memory,
// initialise the state vector to |0...0>, pulse o_qea_start, count cycles until
// i_qea_complete, then read every state line back over a valid/ready stream.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   i_go, i_qbit_num,     job request and its qubit count / context word count
//   i_ins_num
//   i_ctx_valid/_data,    context input stream (ready only while loading context)
//   o_ctx_ready
//   o_ctx_en/_wea/_addr/  QEA context memory write port
//   _data
//   o_state_ena/_wea/     QEA state memory port (writes during init, reads
//   _addra/_dina          during readback)
//   o_qea_start,          QEA run control
//   i_qea_complete
//   i_qea_state_dout      QEA state memory read data (one-cycle read latency)
//   o_rd_valid/_data,     readback stream of state lines
//   i_rd_ready
//   o_busy, o_done,       job status, error pulse, run-cycle count
//   o_err, o_cycles
//
// Optional feature: define QEA_HOST_SEQ_TIMEOUT_EN to abort a run that has not
// completed after TIMEOUT_CYCLES cycles (o_err pulse, no readback).
module qea_host_seq #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int CYCLE_CNT_WIDTH         = 32,
  parameter int TIMEOUT_CYCLES          = 1000000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 i_ctx_valid,
  input  logic [2*DATA_WIDTH-1:0]              i_ctx_data,
  output logic                                 o_ctx_ready,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [2*DATA_WIDTH-1:0]              o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_state_dina,
  output logic                                 o_qea_start,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*2*DATA_WIDTH-1:0]       i_qea_state_dout,
  output logic                                 o_rd_valid,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_rd_data,
  input  logic                                 i_rd_ready,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [CYCLE_CNT_WIDTH-1:0]           o_cycles
);

  localparam int LINE_W = PE_NUM * 2 * DATA_WIDTH;
  localparam logic [MAX_QBIT_WIDTH-1:0] PEW_Q = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] SAW_Q = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ONE_FX = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  // Amplitude 1.0 in the real field of lane 0 (most significant lane).
  localparam logic [LINE_W-1:0] LINE0 = {ONE_FX, {(LINE_W-DATA_WIDTH){1'b0}}};
  localparam logic [GATE_CONTEXT_ADDR_WIDTH:0] CNT_ONE  = {{GATE_CONTEXT_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [STATE_ADDR_WIDTH-1:0]      ADDR_ONE = {{(STATE_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_CNT_WIDTH-1:0]       CYC_ONE  = {{(CYCLE_CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef QEA_HOST_SEQ_TIMEOUT_EN
  localparam logic [CYCLE_CNT_WIDTH-1:0] TIMEOUT_Q = CYCLE_CNT_WIDTH'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CTX, S_INIT, S_START, S_RUN, S_RD_REQ, S_RD_HOLD, S_DONE
  } state_t;

  // Index of the last state line: 2^(qbit - PE_NUM_WIDTH) - 1.
  function automatic logic [STATE_ADDR_WIDTH-1:0] last_line(input logic [MAX_QBIT_WIDTH-1:0] qbit);
    logic [STATE_ADDR_WIDTH:0] lines;
    lines = {{STATE_ADDR_WIDTH{1'b0}}, 1'b1} << (qbit - PEW_Q);
    lines = lines - {{STATE_ADDR_WIDTH{1'b0}}, 1'b1};
    return lines[STATE_ADDR_WIDTH-1:0];
  endfunction

  state_t                             state_q;
  logic [GATE_CONTEXT_ADDR_WIDTH:0]   ins_q, ctx_cnt_q;
  logic [STATE_ADDR_WIDTH-1:0]        last_q, idx_q;
  logic                               ctx_ready_q, ctx_en_q, ctx_wea_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_q;
  logic [2*DATA_WIDTH-1:0]            ctx_data_q;
  logic                               st_ena_q, st_wea_q;
  logic [STATE_ADDR_WIDTH-1:0]        st_addra_q;
  logic [LINE_W-1:0]                  st_dina_q;
  logic                               start_q, rd_valid_q, done_q, err_q;
  logic [LINE_W-1:0]                  rd_data_q;
  logic [CYCLE_CNT_WIDTH-1:0]         cycles_q, cycles_d;
  logic                               qbit_ok;

  assign qbit_ok  = (i_qbit_num >= PEW_Q) && ((i_qbit_num - PEW_Q) <= SAW_Q);
  assign cycles_d = (&cycles_q) ? cycles_q : cycles_q + CYC_ONE;

  // Outputs are registered and timed to coincide with the state that owns
  // them; context writes trail acceptance by one cycle, so CTX holds one extra
  // cycle after the last beat to let that write retire inside the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ins_q       <= '0;
      ctx_cnt_q   <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      ctx_ready_q <= 1'b0;
      ctx_en_q    <= 1'b0;
      ctx_wea_q   <= 1'b0;
      ctx_addr_q  <= '0;
      ctx_data_q  <= '0;
      st_ena_q    <= 1'b0;
      st_wea_q    <= 1'b0;
      st_addra_q  <= '0;
      st_dina_q   <= '0;
      start_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cycles_q    <= '0;
    end else begin
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_go) begin
            if (qbit_ok) begin
              ins_q     <= i_ins_num;
              last_q    <= last_line(i_qbit_num);
              ctx_cnt_q <= '0;
              if (i_ins_num == '0) begin
                idx_q      <= '0;
                st_ena_q   <= 1'b1;
                st_wea_q   <= 1'b1;
                st_addra_q <= '0;
                st_dina_q  <= LINE0;
                state_q    <= S_INIT;
              end else begin
                ctx_ready_q <= 1'b1;
                state_q     <= S_CTX;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_CTX: begin
          if (ctx_ready_q && i_ctx_valid) begin
            ctx_en_q   <= 1'b1;
            ctx_wea_q  <= 1'b1;
            ctx_addr_q <= ctx_cnt_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
            ctx_data_q <= i_ctx_data;
            ctx_cnt_q  <= ctx_cnt_q + CNT_ONE;
            if (ctx_cnt_q + CNT_ONE == ins_q) ctx_ready_q <= 1'b0;
          end else begin
            ctx_en_q  <= 1'b0;
            ctx_wea_q <= 1'b0;
            if (!ctx_ready_q) begin
              idx_q      <= '0;
              st_ena_q   <= 1'b1;
              st_wea_q   <= 1'b1;
              st_addra_q <= '0;
              st_dina_q  <= LINE0;
              state_q    <= S_INIT;
            end
          end
        end
        S_INIT: begin
          if (idx_q == last_q) begin
            st_ena_q  <= 1'b0;
            st_wea_q  <= 1'b0;
            st_dina_q <= '0;
            start_q   <= 1'b1;
            cycles_q  <= '0;
            state_q   <= S_START;
          end else begin
            idx_q      <= idx_q + ADDR_ONE;
            st_addra_q <= idx_q + ADDR_ONE;
            st_dina_q  <= '0;
          end
        end
        S_START: begin
          cycles_q <= cycles_d;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          if (i_qea_complete) begin
            idx_q      <= '0;
            st_ena_q   <= 1'b1;
            st_wea_q   <= 1'b0;
            st_addra_q <= '0;
            state_q    <= S_RD_REQ;
          end
`ifdef QEA_HOST_SEQ_TIMEOUT_EN
          else if (cycles_q == TIMEOUT_Q) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
`endif
          else begin
            cycles_q <= cycles_d;
          end
        end
        S_RD_REQ: begin
          st_ena_q <= 1'b0;
          state_q  <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          // First cycle here: read data is on i_qea_state_dout; capture it.
          if (!rd_valid_q) begin
            rd_data_q  <= i_qea_state_dout;
            rd_valid_q <= 1'b1;
          end else if (i_rd_ready) begin
            rd_valid_q <= 1'b0;
            if (idx_q == last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q      <= idx_q + ADDR_ONE;
              st_ena_q   <= 1'b1;
              st_addra_q <= idx_q + ADDR_ONE;
              state_q    <= S_RD_REQ;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ctx_ready   = ctx_ready_q;
  assign o_ctx_en      = ctx_en_q;
  assign o_ctx_wea     = ctx_wea_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = st_ena_q;
  assign o_state_wea   = st_wea_q;
  assign o_state_addra = st_addra_q;
  assign o_state_dina  = st_dina_q;
  assign o_qea_start   = start_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_data     = rd_data_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_cycles      = cycles_q;

endmodule

// File: tb/tb_qea_host_seq.sv
// Testbench for qea_host_seq: directed jobs, expected writes and readback
// lines queued at stimulus time and popped by negedge monitors.
module tb_qea_host_seq;
  localparam int DW = 32;
  localparam int LW = 4 * 2 * DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_go;
  logic [5:0]      i_qbit_num;
  logic [16:0]     i_ins_num;
  logic            i_ctx_valid;
  logic [63:0]     i_ctx_data;
  logic            o_ctx_ready, o_ctx_en, o_ctx_wea;
  logic [15:0]     o_ctx_addr;
  logic [63:0]     o_ctx_data;
  logic            o_state_ena, o_state_wea;
  logic [15:0]     o_state_addra;
  logic [LW-1:0]   o_state_dina;
  logic            o_qea_start;
  logic            i_qea_complete;
  logic [LW-1:0]   i_qea_state_dout;
  logic            o_rd_valid;
  logic [LW-1:0]   o_rd_data;
  logic            i_rd_ready;
  logic            o_busy, o_done, o_err;
  logic [31:0]     o_cycles;

  qea_host_seq #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .i_ctx_valid(i_ctx_valid), .i_ctx_data(i_ctx_data), .o_ctx_ready(o_ctx_ready),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .o_qea_start(o_qea_start), .i_qea_complete(i_qea_complete),
    .i_qea_state_dout(i_qea_state_dout), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .i_rd_ready(i_rd_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_cycles(o_cycles)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [LW-1:0] d; } wr_t;
  wr_t           ctx_q[$];
  wr_t           st_q[$];
  logic [LW-1:0] rd_q[$];
  logic [LW-1:0] mem [0:255];
  wr_t           ctx_e, st_e;

  localparam logic [LW-1:0] LINE0 = {32'h4000_0000, {(LW-32){1'b0}}};

  int checks = 0, failures = 0;
  int n_ctx, n_stw, n_rd, n_start, n_done, n_err, rd_req_idx;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [63:0] ctxword(input int k);
    return {32'hC0DE_0000 + 32'(k), 32'h5A5A_0000 ^ 32'(k * 7)};
  endfunction

  // QEA state memory model: one-cycle read latency.
  always @(posedge clk)
    if (o_state_ena && !o_state_wea) i_qea_state_dout <= mem[o_state_addra[7:0]];

  // Readback consumer with a fixed stall pattern.
  initial begin
    logic [7:0] pat;
    pat = 8'b1011_0010;
    i_rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_rd_ready = pat[0];
      pat = {pat[0], pat[7:1]};
    end
  end

  // Monitors.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_ctx_en) begin
        n_ctx++;
        if (ctx_q.size() == 0) fail_now($sformatf("ctx_unexpected addr=%0h", o_ctx_addr));
        else begin
          ctx_e = ctx_q.pop_front();
          chk("ctx_wea", {255'b0, o_ctx_wea}, 1);
          chk("ctx_addr", o_ctx_addr, ctx_e.a);
          chk("ctx_data", o_ctx_data, ctx_e.d);
        end
      end
      if (o_state_ena && o_state_wea) begin
        n_stw++;
        if (st_q.size() == 0) fail_now($sformatf("state_wr_unexpected addr=%0h", o_state_addra));
        else begin
          st_e = st_q.pop_front();
          chk("state_wr_addr", o_state_addra, st_e.a);
          chk("state_wr_data", o_state_dina, st_e.d);
        end
      end
      if (o_state_ena && !o_state_wea) begin
        chk("state_rd_addr", o_state_addra, rd_req_idx);
        rd_req_idx++;
      end
      if (o_rd_valid) begin
        if (rd_q.size() == 0) fail_now("rd_unexpected");
        else begin
          chk("rd_data", o_rd_data, rd_q[0]);
          if (i_rd_ready) begin
            void'(rd_q.pop_front());
            n_rd++;
          end
        end
      end
      if (o_qea_start) n_start++;
      if (o_done) n_done++;
      if (o_err) n_err++;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {o_ctx_ready, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea,
                         o_qea_start, o_rd_valid, o_busy, o_done, o_err}, '0);
    chk({tag, "_addr"}, {o_ctx_addr, o_state_addra}, '0);
    chk({tag, "_ctx_data"}, o_ctx_data, '0);
    chk({tag, "_state_dina"}, o_state_dina, '0);
    chk({tag, "_rd_data"}, o_rd_data, '0);
    chk({tag, "_cycles"}, o_cycles, '0);
  endtask

  task automatic clear_counts();
    n_ctx = 0; n_stw = 0; n_rd = 0; n_start = 0; n_done = 0; n_err = 0; rd_req_idx = 0;
  endtask

  task automatic push_state(input int L, input bit with_rd);
    for (int i = 0; i < L; i++) begin
      st_q.push_back({16'(i), (i == 0) ? LINE0 : {LW{1'b0}}});
      if (with_rd) rd_q.push_back(mem[i]);
    end
  endtask

  task automatic run_job(input int qbit, input int ins, input bit go_in_run);
    int L, k, budget;
    bit acc, found;
    L = 1 << (qbit - 2);
    clear_counts();
    push_state(L, 1'b1);
    @(posedge clk); #1;
    i_go = 1'b1; i_qbit_num = 6'(qbit); i_ins_num = 17'(ins);
    @(posedge clk); #1;
    i_go = 1'b0;
    k = 0; budget = 0;
    while (k < ins && budget < 2000) begin
      i_ctx_valid = ($urandom_range(0, 3) != 0);
      i_ctx_data  = ctxword(k);
      acc = i_ctx_valid && o_ctx_ready;
      @(posedge clk);
      if (acc) begin
        ctx_q.push_back({16'(k), {(LW-64){1'b0}}, ctxword(k)} );
        k++;
      end
      #1;
      budget++;
    end
    i_ctx_valid = 1'b0;
    if (k < ins) fail_now("ctx_stream_timeout");
    found = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (o_qea_start) found = 1;
    end
    if (!found) fail_now("start_timeout");
    chk("start_cycles_zero", o_cycles, 0);
    chk("busy_in_job", {255'b0, o_busy}, 1);
    if (go_in_run) begin
      repeat (10) @(posedge clk);
      #1; i_go = 1'b1; i_qbit_num = 6'd3; i_ins_num = 17'd0;
      @(posedge clk); #1; i_go = 1'b0;
      repeat (29) @(posedge clk);
    end else begin
      repeat (40) @(posedge clk);
    end
    #1; i_qea_complete = 1'b1;
    @(posedge clk); #1; i_qea_complete = 1'b0;
    found = 0;
    for (int t = 0; t < 500 && !found; t++) begin
      @(negedge clk);
      if (o_done) found = 1;
    end
    if (!found) fail_now("done_timeout");
    chk("cycles_at_done", o_cycles, 40);
    @(negedge clk);
    chk("done_pulse_end", {o_done, o_busy}, 2'b00);
    chk("ctx_write_count", n_ctx, ins);
    chk("state_write_count", n_stw, L);
    chk("state_read_count", rd_req_idx, L);
    chk("rd_beat_count", n_rd, L);
    chk("start_pulse_count", n_start, 1);
    chk("done_pulse_count", n_done, 1);
    chk("err_count", n_err, 0);
    chk("queues_drained", ctx_q.size() + st_q.size() + rd_q.size(), 0);
  endtask

  task automatic reject(input int qbit);
    clear_counts();
    @(posedge clk); #1;
    i_go = 1'b1; i_qbit_num = 6'(qbit); i_ins_num = 17'd4;
    @(posedge clk); #1;
    i_go = 1'b0;
    @(negedge clk);
    chk($sformatf("reject_err_q%0d", qbit), {o_err, o_busy}, 2'b10);
    @(negedge clk);
    chk($sformatf("reject_err_end_q%0d", qbit), {o_err, o_busy, o_ctx_ready}, 3'b000);
    repeat (3) @(negedge clk);
    chk($sformatf("reject_no_strobes_q%0d", qbit), n_ctx + n_stw + n_start + rd_req_idx, 0);
  endtask

  initial begin
    bit found;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    i_go = 0; i_qbit_num = 0; i_ins_num = 0; i_ctx_valid = 0; i_ctx_data = 0;
    i_qea_complete = 0; i_qea_state_dout = '0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 8; j++)
        mem[i][j*32 +: 32] = 32'hA000_0000 + 32'(i * 16 + j);
    clear_counts();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    run_job(5, 115, 1'b1);
    reject(1);
    reject(19);
    run_job(2, 0, 1'b0);

    // Reset in the middle of state initialisation.
    clear_counts();
    push_state(8, 1'b0);
    @(posedge clk); #1;
    i_go = 1'b1; i_qbit_num = 6'd5; i_ins_num = 17'd0;
    @(posedge clk); #1;
    i_go = 1'b0;
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (o_state_ena && o_state_wea && o_state_addra == 16'd3) found = 1;
    end
    if (!found) fail_now("init_midpoint_timeout");
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid_init");
    ctx_q.delete(); st_q.delete(); rd_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_job(3, 5, 1'b0);

`ifdef QEA_HOST_SEQ_TIMEOUT_EN
    clear_counts();
    push_state(1, 1'b0);
    @(posedge clk); #1;
    i_go = 1'b1; i_qbit_num = 6'd2; i_ins_num = 17'd0;
    @(posedge clk); #1;
    i_go = 1'b0;
    found = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (o_err) found = 1;
    end
    if (!found) fail_now("timeout_err_missing");
    chk("timeout_cycles", o_cycles, 100);
    chk("timeout_idle", {o_busy, o_done}, 2'b00);
    repeat (4) @(negedge clk);
    chk("timeout_no_readback", n_rd + rd_req_idx + n_done, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qea_host_seq.md
QEA_HOST_SEQ -- requirements
Module: qea_host_seq

Interface
REQ-001 SHALL have parameters (name, default, meaning): PE_NUM_WIDTH 2, log2 of PE count; PE_NUM 4, PE count; DATA_WIDTH 32, real/imag component width; MAX_QBIT_WIDTH 6, qubit-count field width; STATE_ADDR_WIDTH 16; GATE_CONTEXT_ADDR_WIDTH 16; NUM_FRAC_BIT 30, fixed-point fraction bits; CYCLE_CNT_WIDTH 32; TIMEOUT_CYCLES 1000000.
REQ-002 SHALL have ports (name, direction, width, meaning):
 clk in 1 sole clock, rising edge;
 rst_n in 1 asynchronous active-low reset;
 i_go in 1 one-cycle job request; i_qbit_num in MAX_QBIT_WIDTH; i_ins_num in GATE_CONTEXT_ADDR_WIDTH+1, context word count;
 i_ctx_valid in 1, i_ctx_data in 2*DATA_WIDTH, o_ctx_ready out 1: context input stream;
 o_ctx_en, o_ctx_wea out 1; o_ctx_addr out GATE_CONTEXT_ADDR_WIDTH; o_ctx_data out 2*DATA_WIDTH: QEA context port;
 o_state_ena, o_state_wea out 1; o_state_addra out STATE_ADDR_WIDTH; o_state_dina out PE_NUM*2*DATA_WIDTH: QEA state port;
 o_qea_start out 1; i_qea_complete in 1; i_qea_state_dout in PE_NUM*2*DATA_WIDTH;
 o_rd_valid out 1, o_rd_data out PE_NUM*2*DATA_WIDTH, i_rd_ready in 1: readback stream;
 o_busy, o_done, o_err out 1; o_cycles out CYCLE_CNT_WIDTH.

Function
REQ-003 SHALL implement FSM IDLE -> CTX -> INIT -> START -> RUN -> RD_REQ <-> RD_HOLD -> DONE -> IDLE.
REQ-004 IDLE: i_go SHALL be accepted only if PE_NUM_WIDTH <= i_qbit_num and i_qbit_num-PE_NUM_WIDTH <= STATE_ADDR_WIDTH; otherwise o_err=1 for one cycle, state stays IDLE.
REQ-005 i_go outside IDLE SHALL be ignored; i_qbit_num/i_ins_num SHALL be latched on acceptance.
REQ-006 CTX: o_ctx_ready=1; each cycle with i_ctx_valid=1 SHALL drive o_ctx_en=o_ctx_wea=1, o_ctx_data=i_ctx_data, o_ctx_addr=0,1,2,... (registered, 1-cycle latency); exit after i_ins_num beats; i_ins_num=0 skips CTX.
REQ-007 INIT: SHALL write L=2^(qbit-PE_NUM_WIDTH) lines, addresses 0..L-1, one per cycle, o_state_ena=o_state_wea=1; line 0 data = 2^NUM_FRAC_BIT in real field (top DATA_WIDTH bits) of lane 0 (most significant 2*DATA_WIDTH slice), all else 0; other lines all zero.
REQ-008 START: o_qea_start=1 for exactly one cycle; o_cycles cleared to 0 same cycle.
REQ-009 RUN: o_cycles SHALL increment every cycle (saturating at all-ones); i_qea_complete SHALL be sampled only from the cycle after START; on complete go to RD_REQ with read address 0.
REQ-010 RD_REQ: drive o_state_ena=1, o_state_wea=0, address = read index for one cycle; RD_HOLD: capture i_qea_state_dout the following cycle into o_rd_data, o_rd_valid=1, hold stable until i_rd_ready=1.
REQ-011 On handshake: if index=L-1 go to DONE, else index+1 and RD_REQ (max 1 line per 2 cycles).
REQ-012 DONE: o_done=1 for one cycle, then IDLE; o_busy=1 in every state except IDLE.
REQ-013 All QEA-port strobes SHALL be 0 outside their phase; o_ctx_ready=0 outside CTX.
REQ-014 o_cycles SHALL hold its last value until next START.

Reset
REQ-015 rst_n low SHALL immediately force IDLE and all outputs, counters and addresses to 0, including mid-job; no partial job resumes after release.

Configuration
REQ-016 Macro QEA_HOST_SEQ_TIMEOUT_EN defined: RUN SHALL abort when o_cycles reaches TIMEOUT_CYCLES without complete, pulse o_err one cycle, skip readback, return to IDLE with o_done=0. Undefined: no timeout logic, RUN waits indefinitely.

Verification
REQ-017 Defaults, qbit=5, ins=115 words streamed with random valid gaps -> 115 ctx writes, addresses 0..114, data in order.
REQ-018 Same job -> INIT writes 8 lines; line 0 = 0x40000000_00000000 in top lane, zeros elsewhere; single-cycle start.
REQ-019 Model asserts complete 40 cycles after start, i_rd_ready toggling -> 8 readback beats, addresses 0..7, data stable while stalled, o_cycles=40, o_done pulse.
REQ-020 i_go with qbit=1 -> o_err pulse, no QEA strobes; i_go during RUN -> ignored.
REQ-021 rst_n low during INIT -> all outputs 0 asynchronously; next i_go runs full job from CTX address 0.
REQ-022 With QEA_HOST_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, complete never asserted -> o_err after 100 cycles, no o_rd_valid, IDLE.
